// File: rtl/egg_timer_datapath.sv
// Egg-timer time-keeping datapath: BCD setpoint entry, prescaled countdown,
// sticky expiry flag and display blank strobe, driven by the controller state code.
module egg_timer_datapath #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state,
    input  logic [7:0] sw,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       expired,
    output logic       blank
);

    localparam logic [2:0] ST_RESET       = 3'd4;
    localparam logic [2:0] ST_SET_SEC     = 3'd0;
    localparam logic [2:0] ST_SETTING_MIN = 3'd7;
    localparam logic [2:0] ST_SET_MIN     = 3'd1;
    localparam logic [2:0] ST_READY       = 3'd3;
    localparam logic [2:0] ST_TIMER       = 3'd2;
    localparam logic [2:0] ST_FLASH_ON    = 3'd5;
    localparam logic [2:0] ST_FLASH_OFF   = 3'd6;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    logic [7:0]       min_q, min_d;
    logic [7:0]       sec_q, sec_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic             running_q, running_d;
    logic             expired_q, expired_d;
    logic             blank_q, blank_d;

    logic sw_valid;
    logic is_run;
    logic count_active;
    logic tick;

    // Two-digit BCD decrement with digit borrow; callers never pass 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] != 4'd0) begin
            r = {v[7:4], v[3:0] - 4'd1};
        end else begin
            r = {v[7:4] - 4'd1, 4'd9};
        end
        return r;
    endfunction

    always_comb begin
        min_d     = min_q;
        sec_d     = sec_q;
        presc_d   = presc_q;
        expired_d = expired_q;

        sw_valid     = (sw[7:4] <= 4'd9) && (sw[3:0] <= 4'd9);
        is_run       = (state == ST_TIMER) || (state == ST_FLASH_ON) ||
                       (state == ST_FLASH_OFF);
        count_active = is_run && running_q && !expired_q;
        tick         = count_active && (presc_q == TICK_LAST);

        case (state)
            ST_RESET: begin
                min_d     = 8'h00;
                sec_d     = 8'h00;
                presc_d   = '0;
                expired_d = 1'b0;
            end
            ST_SET_SEC: begin
                presc_d = '0;
                if (sw_valid) begin
                    sec_d = (sw[7:4] > 4'd5) ? 8'h59 : sw;
                end
            end
            ST_SETTING_MIN, ST_SET_MIN: begin
                presc_d = '0;
                if (sw_valid) begin
                    min_d = sw;
                end
            end
            ST_READY: begin
                presc_d = '0;
            end
            ST_TIMER, ST_FLASH_ON, ST_FLASH_OFF: begin
                // Once expired everything is frozen until a RESET state or rst.
                if (!expired_q) begin
                    if ((min_q == 8'h00) && (sec_q == 8'h00)) begin
                        expired_d = 1'b1;
                    end else if (tick) begin
                        presc_d = '0;
                        if (sec_q != 8'h00) begin
                            sec_d = bcd_dec(sec_q);
                        end else begin
                            sec_d = 8'h59;
                            min_d = bcd_dec(min_q);
                        end
                        expired_d = (min_d == 8'h00) && (sec_d == 8'h00);
                    end else if (count_active) begin
                        presc_d = presc_q + CNT_W'(1);
                    end else begin
                        presc_d = '0;
                    end
                end
            end
            default: begin
                presc_d = presc_q;
            end
        endcase

        running_d = is_run && !expired_d;
        blank_d   = expired_q && (state == ST_FLASH_OFF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q     <= 8'h00;
            sec_q     <= 8'h00;
            presc_q   <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            blank_q   <= 1'b0;
        end else begin
            min_q     <= min_d;
            sec_q     <= sec_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            expired_q <= expired_d;
            blank_q   <= blank_d;
        end
    end

    assign min_bcd = min_q;
    assign sec_bcd = sec_q;
    assign running = running_q;
    assign expired = expired_q;
    assign blank   = blank_q;

endmodule

// File: tb/tb_egg_timer_datapath.sv
// Directed bench for egg_timer_datapath with a short tick (TICK_DIV=4);
// observations are packed as {min, sec, running, expired, blank}.
module tb_egg_timer_datapath;

    logic       clk;
    logic       rst;
    logic [2:0] state;
    logic [7:0] sw;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       expired;
    logic       blank;

    logic [18:0] obs;
    int checks;
    int errors;

    egg_timer_datapath #(
        .TICK_DIV(4),
        .CNT_W   (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .state  (state),
        .sw     (sw),
        .min_bcd(min_bcd),
        .sec_bcd(sec_bcd),
        .running(running),
        .expired(expired),
        .blank  (blank)
    );

    assign obs = {min_bcd, sec_bcd, running, expired, blank};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [7:0] m, input logic [7:0] s);
        state = 3'd4; step(1);
        state = 3'd0; sw = s; step(1);
        state = 3'd1; sw = m; step(1);
        state = 3'd3; step(1);
    endtask

    task automatic test_reset();
        logic [18:0] exp_v;
        rst = 1'b1; state = 3'd4; sw = 8'h00;
        step(2);
        exp_v = {8'h00, 8'h00, 3'b000};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, exp_v);
        end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_entry();
        logic [7:0]  sw_tab[7]   = '{8'h45, 8'h75, 8'h4B, 8'h3A, 8'h02, 8'h99, 8'h11};
        logic [2:0]  st_tab[7]   = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd7, 3'd3};
        logic [15:0] exp_tab[7]  = '{16'h0045, 16'h0059, 16'h0059, 16'h0059,
                                     16'h0259, 16'h9959, 16'h9959};
        logic [18:0] exp_v;
        state = 3'd4; step(1);
        for (int i = 0; i < 7; i++) begin
            state = st_tab[i];
            sw    = sw_tab[i];
            step(1);
            exp_v = {exp_tab[i], 3'b000};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL entry_%0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_countdown();
        logic [15:0] exp_tab[5] = '{16'h0101, 16'h0101, 16'h0100, 16'h0100, 16'h0059};
        int          gap_tab[5] = '{1, 3, 1, 3, 1};
        logic [18:0] exp_v;
        preset(8'h01, 8'h01);
        state = 3'd2;
        for (int i = 0; i < 5; i++) begin
            step(gap_tab[i]);
            exp_v = {exp_tab[i], 3'b100};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL countdown_%0d: got %h expected %h", i, obs, exp_v);
            end
        end
        preset(8'h10, 8'h00);
        state = 3'd2;
        step(5);
        exp_v = {8'h09, 8'h59, 3'b100};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL min_tens_borrow: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_async_reset();
        logic [18:0] exp_v;
        preset(8'h01, 8'h30);
        state = 3'd2;
        step(3);
        exp_v = {8'h01, 8'h30, 3'b100};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL pre_async_reset: got %h expected %h", obs, exp_v);
        end
        #2 rst = 1'b1;
        #1;
        exp_v = '0;
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL async_reset_immediate: got %h expected %h", obs, exp_v);
        end
        state = 3'd4;
        step(1);
        rst = 1'b0;
        step(1);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL async_reset_release: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_expiry_flash();
        logic [18:0] exp_v;
        preset(8'h00, 8'h02);
        for (int k = 0; k < 89; k++) begin
            state = (k % 2 == 0) ? 3'd5 : 3'd6;
            step(1);
            if (k < 4)      exp_v = {8'h00, 8'h02, 3'b100};
            else if (k < 8) exp_v = {8'h00, 8'h01, 3'b100};
            else            exp_v = {8'h00, 8'h00, 2'b01, (k % 2 == 1)};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL expiry_flash_k%0d: got %h expected %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_zero_start();
        logic [18:0] exp_v;
        preset(8'h00, 8'h00);
        state = 3'd2;
        exp_v = {8'h00, 8'h00, 3'b010};
        for (int i = 0; i < 6; i++) begin
            step(1);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL zero_start_%0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_sync_clear();
        logic [18:0] exp_v;
        state = 3'd6;
        step(1);
        exp_v = {8'h00, 8'h00, 3'b011};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL blank_after_expiry: got %h expected %h", obs, exp_v);
        end
        state = 3'd4;
        step(1);
        exp_v = '0;
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL sync_clear: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_pause();
        logic [2:0]  st_tab[7]  = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2};
        int          gap_tab[7] = '{1, 8, 1, 9, 1, 3, 1};
        logic [18:0] exp_tab[7] = '{{16'h0010, 3'b100}, {16'h0008, 3'b100},
                                    {16'h0008, 3'b000}, {16'h0008, 3'b000},
                                    {16'h0008, 3'b100}, {16'h0008, 3'b100},
                                    {16'h0007, 3'b100}};
        preset(8'h00, 8'h10);
        for (int i = 0; i < 7; i++) begin
            state = st_tab[i];
            step(gap_tab[i]);
            checks++;
            if (obs !== exp_tab[i]) begin
                errors++;
                $display("FAIL pause_%0d: got %h expected %h", i, obs, exp_tab[i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_entry();
        test_countdown();
        test_async_reset();
        test_expiry_flash();
        test_zero_start();
        test_sync_clear();
        test_pause();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
